word_align_ctrl: RTL and testbench
==================================

// Module: word_align_ctrl
// PURPOSE
//  - Bit-alignment controller for the stream_manipulator barrel shifter on the RX path.
//  - Sweeps OFFSET (and optionally MASK polarity) until the 2-bit sync header in the aligned word is valid for LOCK_GOOD consecutive words.
//  - Holds that alignment while locked; returns to hunting when header errors exceed UNLOCK_BAD within a WINDOW.
//  - Sits between the manipulator's DATA_OUT and its OFFSET/MASK inputs; LOCKED feeds the lane framer.
// PARAMETERS
//  DATA_WIDTH     80  width of the aligned word and of MASK
//  HDR_LSB        64  bit index of the sync header LSB; header = ALIGNED_DATA[HDR_LSB+1:HDR_LSB]
//  MAX_OFFSET     63  highest OFFSET tried (<=63); sweep is 0..MAX_OFFSET
//  SETTLE_CYCLES  4   valid words discarded after any OFFSET/MASK change (>=2)
//  LOCK_GOOD      64  consecutive good headers required to lock
//  WINDOW         64  words per error-monitoring window while locked
//  UNLOCK_BAD     16  bad headers within one WINDOW that drop lock
//  INVERT_EN      1   1: toggle MASK between all-0 and all-1 after each full sweep
// PORTS
//  USER_CLK      in   1           clock; all logic on posedge
//  RESET         in   1           synchronous, active-high reset
//  ENABLE        in   1           0 forces IDLE; 1 runs alignment
//  DATA_VALID    in   1           qualifies ALIGNED_DATA; counters advance only when 1
//  ALIGNED_DATA  in   DATA_WIDTH  DATA_OUT of stream_manipulator
//  OFFSET        out  6           shift amount to stream_manipulator
//  MASK          out  DATA_WIDTH  XOR mask to stream_manipulator: all-0 or all-1
//  LOCKED        out  1           alignment achieved and held
//  LOCK_LOST     out  1           one-cycle pulse on LOCKED->HUNT transition
//  SWEEP_WRAP    out  1           one-cycle pulse when OFFSET wraps MAX_OFFSET->0
// BEHAVIOUR
//  - Reset: state=IDLE, OFFSET=0, MASK=0, LOCKED=0, LOCK_LOST=0, SWEEP_WRAP=0, all counters 0.
//  - good header: bits == 2'b01 or 2'b10; bad: 2'b00 or 2'b11. Evaluated only when DATA_VALID=1.
//  - All outputs are registered. The manipulator sees a new OFFSET one cycle later, hence SETTLE.
//  - States:
//    IDLE:   ENABLE=1 -> SETTLE with settle_cnt=0. OFFSET/MASK keep their current values.
//    SETTLE: count valid words; at SETTLE_CYCLES -> HUNT with good_cnt=0.
//    HUNT:   good -> good_cnt++; good_cnt reaching LOCK_GOOD -> LOCKED (LOCKED=1 same edge).
//            bad -> advance candidate, then SETTLE.
//            Advance: OFFSET++; if OFFSET==MAX_OFFSET -> OFFSET=0, SWEEP_WRAP=1, and MASK=~MASK if INVERT_EN.
//    LOCKED: win_cnt counts valid words, bad_cnt counts bad headers.
//            bad_cnt reaching UNLOCK_BAD -> HUNT: LOCKED=0, LOCK_LOST=1, OFFSET advanced, then SETTLE.
//            win_cnt reaching WINDOW -> clear win_cnt and bad_cnt.
//            If the UNLOCK_BAD-th bad header lands on the last window word, unlock wins.
//  - ENABLE=0 in any state -> IDLE next edge: LOCKED=0, counters cleared, OFFSET/MASK held. No LOCK_LOST pulse.
//  - RESET mid-operation overrides everything and returns all outputs to their reset values next edge.
//  - DATA_VALID=0 freezes every counter and state except the ENABLE/RESET paths.
//  - Counters are sized $clog2(max+1) and saturate; they never wrap.
// STRUCTURE
//  - Shared package (rx_align_pkg): state enum localparams (IDLE, SETTLE, HUNT, LOCKED); SYNC_DATA=2'b01, SYNC_CTRL=2'b10.
//  - One sub-module: sync_hdr_check (combinational; header bits -> good/bad).
//  - The FSM and counters stay flat in word_align_ctrl.
//  - Top-level pairing with stream_manipulator is done in the lane wrapper, not here.
// TESTING
//  - Reset: RESET=1 for 3 cycles -> OFFSET=0, MASK=0, LOCKED=0, no pulses.
//  - Acquire: model with true offset 17, MASK 0, DATA_VALID=1 -> OFFSET steps 0..17, LOCKED rises after 64 good words at 17, stays high.
//  - Polarity: inverted stream, true offset 5, INVERT_EN=1 -> SWEEP_WRAP pulse at 63->0, MASK=all-1, lock at OFFSET=5.
//  - Unlock boundary:
//    15 bad in one window -> LOCKED stays 1.
//    16 bad in one window -> LOCK_LOST pulse, LOCKED=0, OFFSET=18.
//    15 bad split across a window boundary -> stays locked.
//  - Valid gating: DATA_VALID toggled 50% during HUNT -> lock takes 64 valid words; invalid-cycle bad headers are ignored.
//  - Disable/reset mid-hunt: ENABLE=0 at OFFSET=9 -> IDLE, OFFSET stays 9; RESET mid-LOCKED -> OFFSET=0, LOCKED=0, no LOCK_LOST.

Source files
------------

// File: rtl/rx_align_pkg.sv
// Shared types and constants for the RX word-alignment path.
package rx_align_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HUNT   = 2'd2,
    ST_LOCKED = 2'd3
  } align_state_e;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

endpackage

// File: rtl/sync_hdr_check.sv
// Classifies a 2-bit sync header: only the data/control codes count as good.
module sync_hdr_check
  import rx_align_pkg::*;
(
  input  logic [1:0] hdr,
  output logic       hdr_good
);

  always_comb begin
    hdr_good = (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  end

endmodule

// File: rtl/word_align_ctrl.sv
// Bit-alignment controller: sweeps OFFSET/MASK of the barrel shifter until the
// sync header is stable, then monitors header errors per window while locked.
module word_align_ctrl
  import rx_align_pkg::*;
#(
  parameter int DATA_WIDTH    = 80,
  parameter int HDR_LSB       = 64,
  parameter int MAX_OFFSET    = 63,
  parameter int SETTLE_CYCLES = 4,
  parameter int LOCK_GOOD     = 64,
  parameter int WINDOW        = 64,
  parameter int UNLOCK_BAD    = 16,
  parameter int INVERT_EN     = 1
) (
  input  logic                  USER_CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  DATA_VALID,
  input  logic [DATA_WIDTH-1:0] ALIGNED_DATA,
  output logic [5:0]            OFFSET,
  output logic [DATA_WIDTH-1:0] MASK,
  output logic                  LOCKED,
  output logic                  LOCK_LOST,
  output logic                  SWEEP_WRAP
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);

  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
  localparam logic [GW-1:0] GOOD_MAX   = GW'(LOCK_GOOD);
  localparam logic [WW-1:0] WIN_MAX    = WW'(WINDOW);
  localparam logic [BW-1:0] BAD_MAX    = BW'(UNLOCK_BAD);
  localparam logic [5:0]    OFFSET_MAX = 6'(MAX_OFFSET);

  align_state_e  state_q, state_d;
  logic [5:0]    offset_q, offset_d;
  logic          mask_q, mask_d;
  logic          locked_q, locked_d;
  logic          lock_lost_q, lock_lost_d;
  logic          sweep_wrap_q, sweep_wrap_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [BW-1:0] bad_cnt_q, bad_cnt_d;

  logic          hdr_good;
  logic          data_unused;
  logic [SW-1:0] settle_inc;
  logic [GW-1:0] good_inc;
  logic [WW-1:0] win_inc;
  logic [BW-1:0] bad_inc;
  logic [5:0]    adv_offset;
  logic          adv_mask;
  logic          adv_wrap;

  sync_hdr_check u_hdr_check (
    .hdr      (ALIGNED_DATA[HDR_LSB+1:HDR_LSB]),
    .hdr_good (hdr_good)
  );

  // Only the header bits matter here; the payload passes through to the framer.
  always_comb begin
    data_unused = ^ALIGNED_DATA;
  end

  always_comb begin
    settle_inc = (settle_cnt_q == SETTLE_MAX) ? settle_cnt_q : settle_cnt_q + 1'b1;
    good_inc   = (good_cnt_q   == GOOD_MAX)   ? good_cnt_q   : good_cnt_q + 1'b1;
    win_inc    = (win_cnt_q    == WIN_MAX)    ? win_cnt_q    : win_cnt_q + 1'b1;
    bad_inc    = (bad_cnt_q    == BAD_MAX)    ? bad_cnt_q    : bad_cnt_q + 1'b1;
  end

  always_comb begin
    adv_mask = mask_q;
    adv_wrap = 1'b0;
    if (offset_q >= OFFSET_MAX) begin
      adv_offset = '0;
      adv_wrap   = 1'b1;
      if (INVERT_EN != 0) begin
        adv_mask = ~mask_q;
      end
    end else begin
      adv_offset = offset_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    mask_d       = mask_q;
    locked_d     = locked_q;
    lock_lost_d  = 1'b0;
    sweep_wrap_d = 1'b0;
    settle_cnt_d = settle_cnt_q;
    good_cnt_d   = good_cnt_q;
    win_cnt_d    = win_cnt_q;
    bad_cnt_d    = bad_cnt_q;

    if (!ENABLE) begin
      state_d      = ST_IDLE;
      locked_d     = 1'b0;
      settle_cnt_d = '0;
      good_cnt_d   = '0;
      win_cnt_d    = '0;
      bad_cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
        ST_SETTLE: begin
          if (DATA_VALID) begin
            settle_cnt_d = settle_inc;
            if (settle_inc == SETTLE_MAX) begin
              state_d    = ST_HUNT;
              good_cnt_d = '0;
            end
          end
        end
        ST_HUNT: begin
          if (DATA_VALID) begin
            if (hdr_good) begin
              good_cnt_d = good_inc;
              if (good_inc == GOOD_MAX) begin
                state_d   = ST_LOCKED;
                locked_d  = 1'b1;
                win_cnt_d = '0;
                bad_cnt_d = '0;
              end
            end else begin
              offset_d     = adv_offset;
              mask_d       = adv_mask;
              sweep_wrap_d = adv_wrap;
              state_d      = ST_SETTLE;
              settle_cnt_d = '0;
              good_cnt_d   = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (DATA_VALID) begin
            win_cnt_d = win_inc;
            bad_cnt_d = hdr_good ? bad_cnt_q : bad_inc;
            // Unlock is checked first so it wins when it coincides with the window end.
            if (!hdr_good && (bad_inc == BAD_MAX)) begin
              state_d      = ST_SETTLE;
              locked_d     = 1'b0;
              lock_lost_d  = 1'b1;
              offset_d     = adv_offset;
              mask_d       = adv_mask;
              sweep_wrap_d = adv_wrap;
              settle_cnt_d = '0;
              good_cnt_d   = '0;
              win_cnt_d    = '0;
              bad_cnt_d    = '0;
            end else if (win_inc == WIN_MAX) begin
              win_cnt_d = '0;
              bad_cnt_d = '0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge USER_CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      offset_q     <= '0;
      mask_q       <= 1'b0;
      locked_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
      sweep_wrap_q <= 1'b0;
      settle_cnt_q <= '0;
      good_cnt_q   <= '0;
      win_cnt_q    <= '0;
      bad_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      mask_q       <= mask_d;
      locked_q     <= locked_d;
      lock_lost_q  <= lock_lost_d;
      sweep_wrap_q <= sweep_wrap_d;
      settle_cnt_q <= settle_cnt_d;
      good_cnt_q   <= good_cnt_d;
      win_cnt_q    <= win_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
    end
  end

  always_comb begin
    OFFSET     = offset_q;
    MASK       = {DATA_WIDTH{mask_q}};
    LOCKED     = locked_q;
    LOCK_LOST  = lock_lost_q;
    SWEEP_WRAP = sweep_wrap_q;
  end

endmodule

// File: tb/tb_word_align_ctrl.sv
// Directed bench for word_align_ctrl with a closed-loop barrel-shifter model
// that presents a good header only at the true offset/polarity.
module tb_word_align_ctrl;

  localparam int DW = 80;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          valid;
  logic [DW-1:0] data;
  logic [5:0]    offset;
  logic [DW-1:0] mask;
  logic          locked;
  logic          lock_lost;
  logic          sweep_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] off_pipe  = '0;
  logic       mask_pipe = 1'b0;
  logic [5:0] true_off  = '0;
  logic       true_mask = 1'b0;

  always #5 clk = ~clk;

  word_align_ctrl #(
    .DATA_WIDTH    (DW),
    .HDR_LSB       (64),
    .MAX_OFFSET    (63),
    .SETTLE_CYCLES (4),
    .LOCK_GOOD     (64),
    .WINDOW        (64),
    .UNLOCK_BAD    (16),
    .INVERT_EN     (1)
  ) dut (
    .USER_CLK     (clk),
    .RESET        (rst),
    .ENABLE       (en),
    .DATA_VALID   (valid),
    .ALIGNED_DATA (data),
    .OFFSET       (offset),
    .MASK         (mask),
    .LOCKED       (locked),
    .LOCK_LOST    (lock_lost),
    .SWEEP_WRAP   (sweep_wrap)
  );

  // One clock: drive a word from the shifter model, then sample 1 unit after the edge.
  // The shifter registers OFFSET/MASK, so the word reflects the previous cycle's values.
  task automatic tick(input logic v, input logic force_bad);
    logic [DW-1:0] w;
    logic [1:0]    hdr;
    logic [5:0]    pre_off;
    logic          pre_mask;
    w[31:0]  = $urandom;
    w[63:32] = $urandom;
    w[79:64] = 16'($urandom);
    if (!force_bad && off_pipe == true_off && mask_pipe == true_mask)
      hdr = w[70] ? 2'b10 : 2'b01;
    else
      hdr = w[70] ? 2'b11 : 2'b00;
    w[65:64] = hdr;
    valid    = v;
    data     = w;
    pre_off  = offset;
    pre_mask = mask[0];
    @(posedge clk);
    off_pipe  = pre_off;
    mask_pipe = pre_mask;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (2) tick(1'b1, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if (offset !== 6'd0 || mask !== '0) begin
        n_fail++;
        $display("FAIL reset_offset_mask[%0d]: got offset=%0d mask=%h, want 0/0", i, offset, mask);
      end
      n_checks++;
      if ({locked, lock_lost, sweep_wrap} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: got locked/lost/wrap=%b, want 000", i, {locked, lock_lost, sweep_wrap});
      end
    end
    rst = 1'b0;
    en  = 1'b0;
    tick(1'b1, 1'b0);
  endtask

  task automatic test_acquire();
    int         t17 = -1;
    int         wraps = 0;
    int         steps_bad = 0;
    int         drops = 0;
    logic [5:0] prev;
    true_off  = 6'd17;
    true_mask = 1'b0;
    en        = 1'b1;
    prev      = offset;
    for (int i = 0; i < 2000 && !locked; i++) begin
      tick(1'b1, 1'b0);
      if (sweep_wrap) wraps++;
      if (offset != prev && offset != prev + 6'd1) steps_bad++;
      prev = offset;
      if (t17 >= 0) t17++;
      else if (offset == 6'd17) t17 = 0;
    end
    n_checks++;
    if (locked !== 1'b1 || offset !== 6'd17) begin
      n_fail++;
      $display("FAIL acq_lock: got locked=%b offset=%0d, want 1/17", locked, offset);
    end
    n_checks++;
    if (t17 != 68) begin
      n_fail++;
      $display("FAIL acq_latency: got %0d cycles from OFFSET=17 to LOCKED, want 68", t17);
    end
    n_checks++;
    if (steps_bad != 0 || wraps != 0 || mask !== '0) begin
      n_fail++;
      $display("FAIL acq_sweep: got bad_steps=%0d wraps=%0d mask=%h, want 0/0/0", steps_bad, wraps, mask);
    end
    for (int i = 0; i < 64; i++) begin
      tick(1'b1, 1'b0);
      if (!locked || lock_lost) drops++;
    end
    n_checks++;
    if (drops != 0) begin
      n_fail++;
      $display("FAIL acq_hold: got %0d cycles unlocked, want 0", drops);
    end
  endtask

  task automatic test_unlock_15();
    int drops = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1'b1, i < 15);
      if (!locked || lock_lost) drops++;
    end
    n_checks++;
    if (drops != 0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL unlock15: got drops=%0d locked=%b, want 0/1", drops, locked);
    end
  endtask

  task automatic test_window_split();
    int drops = 0;
    for (int i = 0; i < 64; i++) begin
      tick(1'b1, i >= 56);
      if (!locked || lock_lost) drops++;
    end
    for (int i = 0; i < 64; i++) begin
      tick(1'b1, i < 8);
      if (!locked || lock_lost) drops++;
    end
    n_checks++;
    if (drops != 0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL window_split: got drops=%0d locked=%b, want 0/1", drops, locked);
    end
  endtask

  task automatic test_unlock_16();
    int drops = 0;
    for (int i = 0; i < 63; i++) begin
      tick(1'b1, i >= 48);
      if (!locked || lock_lost) drops++;
    end
    n_checks++;
    if (drops != 0) begin
      n_fail++;
      $display("FAIL unlock16_pre: got %0d early drops, want 0", drops);
    end
    tick(1'b1, 1'b1);
    n_checks++;
    if (lock_lost !== 1'b1 || locked !== 1'b0 || offset !== 6'd18) begin
      n_fail++;
      $display("FAIL unlock16: got lost=%b locked=%b offset=%0d, want 1/0/18", lock_lost, locked, offset);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (lock_lost !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock16_pulse: got lost=%b one cycle later, want 0", lock_lost);
    end
  endtask

  task automatic test_valid_gating();
    logic v;
    logic seen = 1'b0;
    int   vcnt = 0;
    do_reset();
    true_off  = 6'd3;
    true_mask = 1'b0;
    en        = 1'b1;
    for (int i = 0; i < 3000 && !locked; i++) begin
      v = (i % 2 == 0);
      tick(v, !v);
      if (seen && v) vcnt++;
      if (!seen && offset == 6'd3) seen = 1'b1;
    end
    n_checks++;
    if (locked !== 1'b1 || offset !== 6'd3) begin
      n_fail++;
      $display("FAIL gating_lock: got locked=%b offset=%0d, want 1/3", locked, offset);
    end
    n_checks++;
    if (vcnt != 68) begin
      n_fail++;
      $display("FAIL gating_count: got %0d valid words from OFFSET=3 to LOCKED, want 68", vcnt);
    end
  endtask

  task automatic test_polarity();
    int         wraps = 0;
    int         wrap_bad = 0;
    logic [5:0] prev;
    do_reset();
    true_off  = 6'd5;
    true_mask = 1'b1;
    en        = 1'b1;
    for (int i = 0; i < 3000 && !locked; i++) begin
      prev = offset;
      tick(1'b1, 1'b0);
      if (sweep_wrap) begin
        wraps++;
        if (prev != 6'd63 || offset != 6'd0 || mask != {DW{1'b1}}) wrap_bad++;
      end
    end
    n_checks++;
    if (wraps != 1 || wrap_bad != 0) begin
      n_fail++;
      $display("FAIL pol_wrap: got wraps=%0d bad_wraps=%0d, want 1/0", wraps, wrap_bad);
    end
    n_checks++;
    if (locked !== 1'b1 || offset !== 6'd5 || mask !== {DW{1'b1}}) begin
      n_fail++;
      $display("FAIL pol_lock: got locked=%b offset=%0d mask=%h, want 1/5/all-1", locked, offset, mask);
    end
  endtask

  task automatic test_reset_locked();
    rst = 1'b1;
    tick(1'b1, 1'b0);
    rst = 1'b0;
    n_checks++;
    if (offset !== 6'd0 || mask !== '0 || locked !== 1'b0 || lock_lost !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_locked: got offset=%0d mask=%h locked=%b lost=%b, want 0/0/0/0",
               offset, mask, locked, lock_lost);
    end
  endtask

  task automatic test_disable();
    int changes = 0;
    do_reset();
    true_off  = 6'd40;
    true_mask = 1'b0;
    en        = 1'b1;
    for (int i = 0; i < 500 && offset != 6'd9; i++) tick(1'b1, 1'b0);
    en = 1'b0;
    tick(1'b1, 1'b0);
    n_checks++;
    if (offset !== 6'd9 || locked !== 1'b0 || lock_lost !== 1'b0) begin
      n_fail++;
      $display("FAIL disable: got offset=%0d locked=%b lost=%b, want 9/0/0", offset, locked, lock_lost);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      if (offset != 6'd9) changes++;
    end
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      if (offset != 6'd9) changes++;
    end
    n_checks++;
    if (changes != 0) begin
      n_fail++;
      $display("FAIL disable_hold: got %0d cycles with OFFSET!=9, want 0", changes);
    end
    tick(1'b1, 1'b0);
    n_checks++;
    if (offset !== 6'd10) begin
      n_fail++;
      $display("FAIL disable_resume: got offset=%0d, want 10", offset);
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    valid = 1'b0;
    data  = '0;
    test_reset();
    test_acquire();
    test_unlock_15();
    test_window_split();
    test_unlock_16();
    test_valid_gating();
    test_polarity();
    test_reset_locked();
    test_disable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
